// File: rtl/rtc_hms_counter.sv
// BCD hours:minutes:seconds time-of-day counter advanced by rising edges of a
// same-domain 1 Hz square wave, with validated preset load and a run gate.
module rtc_hms_counter #(
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       run_en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam int         HOUR_LAST     = HOUR_MAX - 1;
  localparam logic [7:0] HOUR_LAST_BCD = {4'(HOUR_LAST / 10), 4'(HOUR_LAST % 10)};
  localparam logic [7:0] HOUR_MAX_BIN  = 8'(HOUR_MAX);

  logic       clk_1hz_d_reg;
  logic [7:0] hh_reg, hh_next;
  logic [7:0] mm_reg, mm_next;
  logic [7:0] ss_reg, ss_next;
  logic       sec_tick_reg, sec_tick_next;
  logic       min_tick_reg, min_tick_next;
  logic       day_tick_reg, day_tick_next;
  logic       load_err_reg, load_err_next;

  logic       tick;
  logic       advance;
  logic       ss_wrap;
  logic       mm_wrap;
  logic       hh_wrap;

  // Increment of a two-digit BCD value; callers handle the wrap point.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign tick    = clk_1hz & ~clk_1hz_d_reg;
  assign advance = tick & run_en & ~load;

  // Magnitude compares on BCD are monotonic, so >= also catches anything past the wrap.
  assign ss_wrap = (ss_reg >= 8'h59);
  assign mm_wrap = (mm_reg >= 8'h59);
  assign hh_wrap = (hh_reg >= HOUR_LAST_BCD);

  // ---------------- preset validation ----------------
  logic [23:0] load_bus;
  logic [5:0]  digit_ok;
  logic [7:0]  load_hh_dec;
  logic        ss_ok;
  logic        mm_ok;
  logic        hh_ok;
  logic        load_valid;

  assign load_bus = {load_hh, load_mm, load_ss};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_ok[gi] = (load_bus[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign load_hh_dec = ({4'd0, load_hh[7:4]} * 8'd10) + {4'd0, load_hh[3:0]};
  assign ss_ok       = (load_ss[7:4] <= 4'd5);
  assign mm_ok       = (load_mm[7:4] <= 4'd5);
  assign hh_ok       = (load_hh_dec < HOUR_MAX_BIN);
  assign load_valid  = (&digit_ok) & ss_ok & mm_ok & hh_ok;

  // ---------------- next-state ----------------
  always_comb begin
    hh_next       = hh_reg;
    mm_next       = mm_reg;
    ss_next       = ss_reg;
    sec_tick_next = 1'b0;
    min_tick_next = 1'b0;
    day_tick_next = 1'b0;
    load_err_next = 1'b0;

    if (load) begin
      // A tick in the same cycle as a load is deliberately lost.
      if (load_valid) begin
        hh_next = load_hh;
        mm_next = load_mm;
        ss_next = load_ss;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (advance) begin
      sec_tick_next = 1'b1;
      if (ss_wrap) begin
        ss_next       = 8'h00;
        min_tick_next = 1'b1;
        if (mm_wrap) begin
          mm_next = 8'h00;
          if (hh_wrap) begin
            hh_next       = 8'h00;
            day_tick_next = 1'b1;
          end else begin
            hh_next = bcd_inc(hh_reg);
          end
        end else begin
          mm_next = bcd_inc(mm_reg);
        end
      end else begin
        ss_next = bcd_inc(ss_reg);
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_1hz_d_reg <= 1'b0;
      hh_reg        <= 8'h00;
      mm_reg        <= 8'h00;
      ss_reg        <= 8'h00;
      sec_tick_reg  <= 1'b0;
      min_tick_reg  <= 1'b0;
      day_tick_reg  <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      clk_1hz_d_reg <= clk_1hz;
      hh_reg        <= hh_next;
      mm_reg        <= mm_next;
      ss_reg        <= ss_next;
      sec_tick_reg  <= sec_tick_next;
      min_tick_reg  <= min_tick_next;
      day_tick_reg  <= day_tick_next;
      load_err_reg  <= load_err_next;
    end
  end

  assign hh       = hh_reg;
  assign mm       = mm_reg;
  assign ss       = ss_reg;
  assign sec_tick = sec_tick_reg;
  assign min_tick = min_tick_reg;
  assign day_tick = day_tick_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Scoreboard bench for rtc_hms_counter: a decimal time model predicts every cycle's
// outputs, which are queued and compared against the DUT once per clock.
module tb_rtc_hms_counter;

  localparam int HOUR_MAX = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_1hz;
  logic       run_en;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;
  logic       load_err;

  rtc_hms_counter #(.HOUR_MAX(HOUR_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_1hz  (clk_1hz),
    .run_en   (run_en),
    .load     (load),
    .load_hh  (load_hh),
    .load_mm  (load_mm),
    .load_ss  (load_ss),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .sec_tick (sec_tick),
    .min_tick (min_tick),
    .day_tick (day_tick),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       c;
    logic       run;
    logic       ld;
    logic [7:0] lh;
    logic [7:0] lm;
    logic [7:0] ls;
  } stim_t;

  stim_t       stq[$];
  logic [27:0] sb[$];
  logic [27:0] obs;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  // Reference model state, kept in plain decimal.
  int   m_h = 0, m_m = 0, m_s = 0;
  logic m_prev = 1'b0;

  assign obs = {hh, mm, ss, sec_tick, min_tick, day_tick, load_err};

  function automatic logic [7:0] to_bcd(input int x);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(x / 10);
    u = 4'(x % 10);
    return {t, u};
  endfunction

  task automatic add(input logic r, input logic c, input logic run, input logic ld,
                     input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    stq.push_back({r, c, run, ld, lh, lm, ls});
  endtask

  task automatic rises(input logic run, input int n);
    for (int i = 0; i < n; i++) begin
      add(1'b1, 1'b0, run, 1'b0, 8'h00, 8'h00, 8'h00);
      add(1'b1, 1'b1, run, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  // Applies one cycle of stimulus, predicts the post-edge outputs, then steps the clock.
  task automatic drive_cycle(input stim_t st);
    logic sec, mi, day, err, tk, ok;
    int   hd, md, sd;
    sec = 1'b0; mi = 1'b0; day = 1'b0; err = 1'b0;
    rst_n = st.r; clk_1hz = st.c; run_en = st.run; load = st.ld;
    load_hh = st.lh; load_mm = st.lm; load_ss = st.ls;
    if (!st.r) begin
      m_h = 0; m_m = 0; m_s = 0; m_prev = 1'b0;
    end else begin
      tk = st.c & ~m_prev;
      m_prev = st.c;
      if (st.ld) begin
        hd = int'(st.lh[7:4]) * 10 + int'(st.lh[3:0]);
        md = int'(st.lm[7:4]) * 10 + int'(st.lm[3:0]);
        sd = int'(st.ls[7:4]) * 10 + int'(st.ls[3:0]);
        ok = (st.lh[7:4] < 10) && (st.lh[3:0] < 10) && (st.lm[7:4] < 10) &&
             (st.lm[3:0] < 10) && (st.ls[7:4] < 10) && (st.ls[3:0] < 10) &&
             (sd < 60) && (md < 60) && (hd < HOUR_MAX);
        if (ok) begin
          m_h = hd; m_m = md; m_s = sd;
        end else begin
          err = 1'b1;
        end
      end else if (tk && st.run) begin
        sec = 1'b1;
        m_s++;
        if (m_s == 60) begin
          m_s = 0; mi = 1'b1; m_m++;
          if (m_m == 60) begin
            m_m = 0; m_h++;
            if (m_h == HOUR_MAX) begin
              m_h = 0; day = 1'b1;
            end
          end
        end
      end
    end
    sb.push_back({to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), sec, mi, day, err});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    logic [27:0] e;
    int          pulses = 0;
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    rises(1'b1, 3);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      if (sec_tick) pulses++;
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_count cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    n_cmp++;
    if (pulses !== 3 || ss !== 8'h03) begin
      n_err++;
      $display("FAIL reset_count_total: got %0d pulses ss=%h want 3 pulses ss=03", pulses, ss);
    end
    $display("test_reset done: ss=%h sec_tick pulses=%0d", ss, pulses);
  endtask

  task automatic test_min_wrap();
    logic [27:0] e;
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h59);
    rises(1'b1, 2);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL min_wrap cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    $display("test_min_wrap done: %h:%h:%h", hh, mm, ss);
  endtask

  task automatic test_day_wrap();
    logic [27:0] e;
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h59);
    rises(1'b1, 1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 8'h59, 8'h59);
    rises(1'b1, 1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h19, 8'h09, 8'h49);
    rises(1'b1, 12);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL day_wrap cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    $display("test_day_wrap done: %h:%h:%h", hh, mm, ss);
  endtask

  task automatic test_load_invalid();
    logic [27:0] e;
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 8'h1A);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h60, 8'h05);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h24, 8'h00, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h0B, 8'h00, 8'h00);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h00, 8'h99);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h59);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL load_invalid cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    $display("test_load_invalid done: %h:%h:%h", hh, mm, ss);
  endtask

  task automatic test_load_priority();
    logic [27:0] e;
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    rises(1'b1, 1);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL load_priority cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    $display("test_load_priority done: %h:%h:%h", hh, mm, ss);
  endtask

  task automatic test_run_gate();
    logic [27:0] e;
    int          pulses = 0;
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 8'h30, 8'h10);
    rises(1'b0, 5);
    rises(1'b1, 1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    while (stq.size() > 0) begin
      if (stq.size() == 10) pulses = 0;
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      if (sec_tick) pulses++;
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL run_gate cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    n_cmp++;
    if (pulses !== 1 || ss !== 8'h12) begin
      n_err++;
      $display("FAIL run_gate_hold: got %0d advances ss=%h want 1 advance ss=12", pulses, ss);
    end
    $display("test_run_gate done: ss=%h advances during hold=%0d", ss, pulses);
  endtask

  task automatic test_reset_mid();
    logic [27:0] e;
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    rises(1'b1, 2);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    while (stq.size() > 0) begin
      drive_cycle(stq.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", cyc, obs, e);
      end
    end
    $display("test_reset_mid done: %h:%h:%h", hh, mm, ss);
  endtask

  initial begin
    rst_n = 1'b0; clk_1hz = 1'b0; run_en = 1'b0; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    @(negedge clk);
    test_reset();
    test_min_wrap();
    test_day_wrap();
    test_load_invalid();
    test_load_priority();
    test_run_gate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
